// File: rtl/orion_types.sv
// Shared core types: bus widths, arbiter source IDs and the default in-flight limit.
package orion_types;
  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = XLEN / 8;

  localparam int MEM_ARB_MAX_OUTST = 2;

  typedef enum logic {
    ARB_SRC_IMEM = 1'b0,
    ARB_SRC_DMEM = 1'b1
  } arb_src_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory request/response channels around mem_arbiter.
// slave = the arbiter's view; master = the core/memory environment.
interface mem_arbiter_if;
  import orion_types::*;

  logic             imem_req_valid_i;
  logic [ADDRW-1:0] imem_req_addr_i;
  logic             imem_req_ready_o;
  logic             imem_rsp_valid_o;
  logic [XLEN-1:0]  imem_rsp_rdata_o;

  logic             dmem_req_valid_i;
  logic [ADDRW-1:0] dmem_req_addr_i;
  logic [MASKW-1:0] dmem_req_mask_i;
  logic [XLEN-1:0]  dmem_req_wdata_i;
  logic             dmem_req_we_i;
  logic             dmem_req_ready_o;
  logic             dmem_rsp_valid_o;
  logic [XLEN-1:0]  dmem_rsp_rdata_o;

  logic             mem_req_valid_o;
  logic             mem_req_ready_i;
  logic [ADDRW-1:0] mem_req_addr_o;
  logic [MASKW-1:0] mem_req_mask_o;
  logic [XLEN-1:0]  mem_req_wdata_o;
  logic             mem_req_we_o;
  logic             mem_rsp_valid_i;
  logic [XLEN-1:0]  mem_rsp_rdata_i;

  modport slave (
    input  imem_req_valid_i, imem_req_addr_i,
    output imem_req_ready_o, imem_rsp_valid_o, imem_rsp_rdata_o,
    input  dmem_req_valid_i, dmem_req_addr_i, dmem_req_mask_i, dmem_req_wdata_i, dmem_req_we_i,
    output dmem_req_ready_o, dmem_rsp_valid_o, dmem_rsp_rdata_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_mask_o, mem_req_wdata_o, mem_req_we_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i
  );

  modport master (
    output imem_req_valid_i, imem_req_addr_i,
    input  imem_req_ready_o, imem_rsp_valid_o, imem_rsp_rdata_o,
    output dmem_req_valid_i, dmem_req_addr_i, dmem_req_mask_i, dmem_req_wdata_i, dmem_req_we_i,
    input  dmem_req_ready_o, dmem_rsp_valid_o, dmem_rsp_rdata_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_mask_o, mem_req_wdata_o, mem_req_we_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i
  );
endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit source IDs; pointers wrap at DEPTH so any depth >= 1 works.
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters with in-order response routing.
// Define ORION_ARB_RR_EN for round-robin ties; otherwise DMEM wins ties.
module mem_arbiter
  import orion_types::*;
#(
  parameter int MAX_OUTST = MEM_ARB_MAX_OUTST
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_OUTST + 1);

  arb_src_e      sel, tie_src, lock_src_q, head_src;
  logic          lock_q, can_issue, req_valid, handshake, rsp_pop;
  logic          head, fifo_full, fifo_empty;
  logic [CW-1:0] cnt_q;

`ifdef ORION_ARB_RR_EN
  arb_src_e last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          last_q <= ARB_SRC_IMEM;
    else if (handshake) last_q <= sel;
  end

  assign tie_src = (last_q == ARB_SRC_IMEM) ? ARB_SRC_DMEM : ARB_SRC_IMEM;
`else
  assign tie_src = ARB_SRC_DMEM;
`endif

  // A stalled request keeps its source so the memory-side payload never changes under valid.
  always_comb begin
    sel = ARB_SRC_IMEM;
    if (lock_q)
      sel = lock_src_q;
    else if (bus.dmem_req_valid_i && bus.imem_req_valid_i)
      sel = tie_src;
    else if (bus.dmem_req_valid_i)
      sel = ARB_SRC_DMEM;
  end

  // Gate on the registered count only: no combinational response-to-ready path.
  assign can_issue = !rst_i && (cnt_q < CW'(MAX_OUTST));
  assign req_valid = (sel == ARB_SRC_DMEM) ? bus.dmem_req_valid_i : bus.imem_req_valid_i;
  assign handshake = bus.mem_req_valid_o && bus.mem_req_ready_i;

  assign bus.mem_req_valid_o  = can_issue && req_valid;
  assign bus.imem_req_ready_o = can_issue && (sel == ARB_SRC_IMEM) && bus.mem_req_ready_i;
  assign bus.dmem_req_ready_o = can_issue && (sel == ARB_SRC_DMEM) && bus.mem_req_ready_i;

  always_comb begin
    bus.mem_req_addr_o  = bus.imem_req_addr_i;
    bus.mem_req_mask_o  = '1;
    bus.mem_req_wdata_o = '0;
    bus.mem_req_we_o    = 1'b0;
    if (sel == ARB_SRC_DMEM) begin
      bus.mem_req_addr_o  = bus.dmem_req_addr_i;
      bus.mem_req_mask_o  = bus.dmem_req_mask_i;
      bus.mem_req_wdata_o = bus.dmem_req_wdata_i;
      bus.mem_req_we_o    = bus.dmem_req_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= ARB_SRC_IMEM;
    end else if (handshake) begin
      lock_q <= 1'b0;
    end else if (bus.mem_req_valid_o) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel;
    end
  end

  arb_id_fifo #(.DEPTH(MAX_OUTST), .CW(CW)) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (handshake),
    .din   (sel == ARB_SRC_DMEM),
    .pop   (rsp_pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cnt_q)
  );

  // Responses with nothing in flight are dropped rather than routed.
  assign rsp_pop  = bus.mem_rsp_valid_i && !fifo_empty;
  assign head_src = head ? ARB_SRC_DMEM : ARB_SRC_IMEM;

  assign bus.imem_rsp_valid_o = !rst_i && rsp_pop && (head_src == ARB_SRC_IMEM);
  assign bus.dmem_rsp_valid_o = !rst_i && rsp_pop && (head_src == ARB_SRC_DMEM);
  assign bus.imem_rsp_rdata_o = bus.mem_rsp_rdata_i;
  assign bus.dmem_rsp_rdata_o = bus.mem_rsp_rdata_i;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && bus.mem_rsp_valid_i) begin
      assert (!fifo_empty)
        else $warning("mem_arbiter: memory response with no request in flight");
    end
    if (!rst_i && handshake) begin
      assert (!fifo_full)
        else $error("mem_arbiter: issue with in-flight tracking full");
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model (queue of in-flight sources).
module tb_mem_arbiter;
  import orion_types::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.MAX_OUTST(MAXO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference state
  arb_src_e   inflight[$];
  bit         lock_m;
  arb_src_e   lock_src_m, last_m;

  // Requester / memory stimulus state
  bit               iv, dv, dwe, rdy, rv;
  logic [ADDRW-1:0] ia, da;
  logic [MASKW-1:0] dmask;
  logic [XLEN-1:0]  dwdata, rdata;
  int p_ireq, p_dreq, p_rdy, p_rsp;

  function automatic arb_src_e pick();
    if (lock_m) return lock_src_m;
    if (iv && !dv) return ARB_SRC_IMEM;
    if (dv && !iv) return ARB_SRC_DMEM;
    if (iv && dv) begin
`ifdef ORION_ARB_RR_EN
      return (last_m == ARB_SRC_IMEM) ? ARB_SRC_DMEM : ARB_SRC_IMEM;
`else
      return ARB_SRC_DMEM;
`endif
    end
    return ARB_SRC_IMEM;
  endfunction

  task automatic drive();
    bus.imem_req_valid_i = iv;
    bus.imem_req_addr_i  = ia;
    bus.dmem_req_valid_i = dv;
    bus.dmem_req_addr_i  = da;
    bus.dmem_req_mask_i  = dmask;
    bus.dmem_req_wdata_i = dwdata;
    bus.dmem_req_we_i    = dwe;
    bus.mem_req_ready_i  = rdy;
    bus.mem_rsp_valid_i  = rv;
    bus.mem_rsp_rdata_i  = rdata;
  endtask

  task automatic model_reset();
    inflight.delete();
    lock_m     = 0;
    lock_src_m = ARB_SRC_IMEM;
    last_m     = ARB_SRC_IMEM;
    iv = 0; dv = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic step();
    arb_src_e s;
    bit can, ev, hs;
    @(negedge clk);
    if (!iv && $urandom_range(99) < p_ireq) begin
      iv = 1; ia = $urandom;
    end
    if (!dv && $urandom_range(99) < p_dreq) begin
      dv = 1; da = {$urandom} & ~32'h3;
      if ($urandom_range(3) == 0) begin
        dwe = 1; dmask = 4'b0100; dwdata = 32'h00AB0000;
      end else begin
        dwe = 1'($urandom); dmask = 4'($urandom_range(15, 1)); dwdata = $urandom;
      end
    end
    rdy   = ($urandom_range(99) < p_rdy);
    rv    = (inflight.size() > 0) && ($urandom_range(99) < p_rsp);
    rdata = $urandom;
    drive();
    #1;
    s   = pick();
    can = inflight.size() < MAXO;
    ev  = can && ((s == ARB_SRC_IMEM) ? iv : dv);
    hs  = ev && rdy;
    chk("cnt", 64'(dut.cnt_q), 64'(inflight.size()));
    chk("mem_req_valid", 64'(bus.mem_req_valid_o), 64'(ev));
    chk("imem_ready", 64'(bus.imem_req_ready_o), 64'(can && rdy && s == ARB_SRC_IMEM));
    chk("dmem_ready", 64'(bus.dmem_req_ready_o), 64'(can && rdy && s == ARB_SRC_DMEM));
    if (ev) begin
      chk("req_addr",  64'(bus.mem_req_addr_o),  64'((s == ARB_SRC_IMEM) ? ia : da));
      chk("req_mask",  64'(bus.mem_req_mask_o),  64'((s == ARB_SRC_IMEM) ? 4'hF : dmask));
      chk("req_wdata", 64'(bus.mem_req_wdata_o), 64'((s == ARB_SRC_IMEM) ? 32'h0 : dwdata));
      chk("req_we",    64'(bus.mem_req_we_o),    64'((s == ARB_SRC_IMEM) ? 1'b0 : dwe));
    end
    chk("imem_rsp_valid", 64'(bus.imem_rsp_valid_o), 64'(rv && inflight[0] == ARB_SRC_IMEM));
    chk("dmem_rsp_valid", 64'(bus.dmem_rsp_valid_o), 64'(rv && inflight[0] == ARB_SRC_DMEM));
    if (rv) begin
      chk("imem_rsp_rdata", 64'(bus.imem_rsp_rdata_o), 64'(rdata));
      chk("dmem_rsp_rdata", 64'(bus.dmem_rsp_rdata_o), 64'(rdata));
    end
    @(posedge clk);
    if (rv) void'(inflight.pop_front());
    if (hs) begin
      inflight.push_back(s);
      lock_m = 0;
      last_m = s;
      if (s == ARB_SRC_IMEM) iv = 0; else dv = 0;
    end else if (ev) begin
      lock_m     = 1;
      lock_src_m = s;
    end
  endtask

  task automatic run(input int n, input int pi, input int pd, input int pr, input int ps);
    p_ireq = pi; p_dreq = pd; p_rdy = pr; p_rsp = ps;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, 64'(bus.mem_req_valid_o), 64'd0);
    chk({tag, "_imem_ready"}, 64'(bus.imem_req_ready_o), 64'd0);
    chk({tag, "_dmem_ready"}, 64'(bus.dmem_req_ready_o), 64'd0);
    chk({tag, "_imem_rsp"}, 64'(bus.imem_rsp_valid_o), 64'd0);
    chk({tag, "_dmem_rsp"}, 64'(bus.dmem_rsp_valid_o), 64'd0);
    chk({tag, "_cnt"}, 64'(dut.cnt_q), 64'd0);
  endtask

  initial begin
    model_reset();
    ia = '0; da = '0; dmask = '0; dwdata = '0; dwe = 0; rdy = 1; rv = 0; rdata = '0;
    drive();
    bus.imem_req_valid_i = 1'b1;
    bus.dmem_req_valid_i = 1'b1;
    bus.mem_rsp_valid_i  = 1'b1;
    #12;
    check_reset_outputs("por");
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive();

    run(40, 100, 100, 100, 100);  // back-to-back ties, responses one cycle later
    run(300, 60, 60, 60, 50);     // mixed backpressure and response delay
    run(150, 80, 80, 30, 15);     // slow memory: locks and in-flight limit
    run(60, 100, 100, 100, 0);    // responses withheld: issue stalls at the limit
    run(40, 90, 90, 80, 70);

    // Load the pipe with two in flight, then reset mid-operation.
    run(30, 100, 100, 100, 0);
    @(negedge clk);
    rst = 1'b1;
    iv = 1; dv = 1; rdy = 1; rv = 1;
    drive();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rv = 1; rdy = 1;
    drive();
    #1;
    chk("stray_imem_rsp", 64'(bus.imem_rsp_valid_o), 64'd0);
    chk("stray_dmem_rsp", 64'(bus.dmem_rsp_valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk("stray_cnt", 64'(dut.cnt_q), 64'd0);
    rv = 0;
    drive();

    run(100, 70, 70, 70, 60);  // normal operation resumes after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction-fetch requester (read-only) and the execute-stage data requester (load/store), so the core can run from one unified memory. Sits between fetch/execute and the memory subsystem. Arbitrates per request with a valid/ready handshake, tracks up to `MAX_OUTST` in-flight requests in issue order, and routes each in-order response back to the requester that issued it.

## Interface
- `MAX_OUTST`, 2: maximum requests accepted by memory and not yet answered (≥1).
- `clk_i`  in  1: clock. One clock domain.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `imem_req_valid_i`  in  1: fetch request.
- `imem_req_addr_i`  in  ADDRW: fetch word address.
- `imem_req_ready_o`  out  1: fetch request accepted this cycle.
- `imem_rsp_valid_o`  out  1: fetch response.
- `imem_rsp_rdata_o`  out  XLEN: fetch data.
- `dmem_req_valid_i`  in  1: data request.
- `dmem_req_addr_i`  in  ADDRW: word-aligned address.
- `dmem_req_mask_i`  in  MASKW: byte mask.
- `dmem_req_wdata_i`  in  XLEN: store data.
- `dmem_req_we_i`  in  1: 1 = store.
- `dmem_req_ready_o`  out  1: data request accepted this cycle.
- `dmem_rsp_valid_o`  out  1: data response. Load data, or store acknowledge.
- `dmem_rsp_rdata_o`  out  XLEN: load data.
- `mem_req_valid_o`  out  1: request to memory.
- `mem_req_ready_i`  in  1: memory accepts the request.
- `mem_req_addr_o`  out  ADDRW: request address.
- `mem_req_mask_o`  out  MASKW: byte mask. Fetch requests drive all ones.
- `mem_req_wdata_o`  out  XLEN: write data. Fetch requests drive 0.
- `mem_req_we_o`  out  1: write enable. Fetch requests drive 0.
- `mem_rsp_valid_i`  in  1: memory response. Exactly one per accepted request, in order. No backpressure.
- `mem_rsp_rdata_i`  in  XLEN: response data.

## Operation
- **Handshake.** A transfer occurs when valid and ready are both high at a rising edge. Requesters hold valid and payload stable until ready. The memory side follows the same rule.
- **Issue gating.**
  - `cnt_q` counts requests in flight.
  - No request is issued while `cnt_q == MAX_OUTST`. This holds even if a response arrives in the same cycle, so there is no combinational path from the response to ready.
  - Requester ready = the requester is granted && `mem_req_ready_i` && `cnt_q < MAX_OUTST`.
- **Arbitration.**
  - Combinational when unlocked.
  - If only one requester is valid, it is granted.
  - If both are valid, the winner is set by the policy (see Configuration).
- **Grant lock.**
  - Set when `mem_req_valid_o && !mem_req_ready_i`. While set, the granted source (`lock_src_q`) stays selected even if the other requester becomes valid.
  - Cleared on the handshake.
  - The memory side therefore never sees its payload change while valid is high.
- **Source FIFO.**
  - Each accepted request pushes its source ID.
  - Each `mem_rsp_valid_i` pops the head.
  - Response routing is combinational: `X_rsp_valid_o = mem_rsp_valid_i && head == X`. `X_rsp_rdata_o = mem_rsp_rdata_i` for both ports.
- **Counter update.** `cnt_q` changes by +push −pop. A simultaneous push and pop leaves it unchanged.
- **Protocol error.** `mem_rsp_valid_i` with the FIFO empty is an error: no pop, no response valid, `cnt_q` stays 0.
- **Unselected payload.** `mem_req_*` payload is don't-care while `mem_req_valid_o` is low. The implementation drives the fetch payload.

## Timing
- **Reset state.** FIFO empty, `cnt_q = 0`, lock clear, RR pointer = "IMEM last granted", so DMEM wins the first tie.
- **Outputs during reset.** While `rst_i` is high, all `*_valid_o` and `*_ready_o` are forced to 0.
- **Request latency.** 0 cycles, requester to `mem_req_valid_o`, combinational.
- **Response latency.** 0 cycles, `mem_rsp_valid_i` to `X_rsp_valid_o`.
- **Throughput.** One request per cycle while `cnt_q < MAX_OUTST`.
- **Reset mid-operation.** In-flight IDs are discarded. Responses that arrive after reset count as protocol errors and are dropped.

## Configuration
- `ORION_ARB_RR_EN` defined:
  - Round-robin on ties: the source not granted last wins.
  - The pointer updates only on a handshake.
- Not defined:
  - Fixed priority: DMEM always wins ties.
  - The pointer register is not built.

## Structure
- **Shared package (`orion_types`).**
  - `arb_src_e` with `ARB_SRC_IMEM = 1'b0`, `ARB_SRC_DMEM = 1'b1`.
  - `MEM_ARB_MAX_OUTST` default constant.
  - `ADDRW`, `XLEN`, `MASKW` already live there.
- **Sub-module `arb_id_fifo`.**
  - Parameterized depth, 1-bit entries.
  - Ports: push, pop, head, full, empty, count.
  - Pointer wrap at the depth, so non-power-of-2 depths work.
- **Arbitration and lock.** Inline in `mem_arbiter`.
- **Assertion.** Under `ifndef SYNTHESIS`, assert on a response with the FIFO empty.

## Test plan
- Both requesters valid, `mem_req_ready_i = 1`, memory returns data 1 cycle after each request:
  - With `ORION_ARB_RR_EN`, grants alternate DMEM, IMEM, DMEM… and each `X_rsp_valid_o` pulse carries that source's data.
  - Without the macro, only DMEM is granted while it stays valid.
- IMEM valid alone, `mem_req_ready_i = 0` for 3 cycles, DMEM becomes valid in cycle 1:
  - `mem_req_addr_o` stays the IMEM address and `mem_req_mask_o` stays 4'b1111 until ready.
  - DMEM is granted next.
- `MAX_OUTST = 2`, memory accepts but withholds responses:
  - After 2 handshakes, `mem_req_valid_o = 0` and both readys are 0.
  - One response drops `cnt_q` to 1. The next cycle issues again.
- Response and a new request in the same cycle with `cnt_q = 1`: `cnt_q` stays 1, and the FIFO head advances to the next ID.
- Store from DMEM (we = 1, mask 4'b0100, wdata 0x00AB0000): memory sees an identical payload, and `dmem_rsp_valid_o` pulses once as the acknowledge.
- `rst_i` pulsed while 2 requests are in flight:
  - Outputs are forced to 0 during reset.
  - After release, a stray `mem_rsp_valid_i` produces no response valid, `cnt_q` stays 0, and the assertion fires.
